// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_port_responder
//  Brief    : Memory-mapped I/O responder on the MEM-stage data bus. Owns two
//             debounced switch inputs, four output ports, a sticky W1C status
//             register with interrupt mask, and a compare timer. Loads return
//             data combinationally; stores commit on the rising clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_port_responder #(
  parameter int IN_WIDTH        = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [IN_WIDTH-1:0] in_port0,
  input  logic [IN_WIDTH-1:0] in_port1,
  output logic [31:0]         out_port0,
  output logic [31:0]         out_port1,
  output logic [31:0]         out_port2,
  output logic [31:0]         out_port3,
  output logic                irq
);

  // Word offsets (addr[7:2]) of the register map.
  localparam logic [5:0] c_off_in0     = 6'h20;  // 0x80
  localparam logic [5:0] c_off_in1     = 6'h21;  // 0x84
  localparam logic [5:0] c_off_status  = 6'h22;  // 0x88
  localparam logic [5:0] c_off_mask    = 6'h23;  // 0x8C
  localparam logic [5:0] c_off_out0    = 6'h30;  // 0xC0
  localparam logic [5:0] c_off_out1    = 6'h31;  // 0xC4
  localparam logic [5:0] c_off_out2    = 6'h32;  // 0xC8
  localparam logic [5:0] c_off_out3    = 6'h33;  // 0xCC
  localparam logic [5:0] c_off_count   = 6'h34;  // 0xD0
  localparam logic [5:0] c_off_compare = 6'h35;  // 0xD4
  localparam logic [5:0] c_off_ctrl    = 6'h36;  // 0xD8

  // Stability counter sized to hold DEBOUNCE_CYCLES itself.
  localparam int                  c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0]  c_db_max  = c_cnt_w'(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0]  c_db_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam bit                  c_db_one  = (DEBOUNCE_CYCLES == 1);

  logic                r_timer_en;
  logic [31:0]         r_count;
  logic [31:0]         r_compare;
  logic [2:0]          r_status;
  logic [2:0]          r_irq_mask;
  logic [31:0]         r_out0;
  logic [31:0]         r_out1;
  logic [31:0]         r_out2;
  logic [31:0]         r_out3;

  logic [5:0]          w_off;
  logic                w_wr;
  logic                w_timer_hit;
  logic [2:0]          w_status_set;
  logic [2:0]          w_status_clr;
  logic [1:0]          w_in_chg;
  logic [IN_WIDTH-1:0] w_raw    [2];
  logic [IN_WIDTH-1:0] w_in_deb [2];
  logic                w_unused_addr_bits;

  assign w_off              = addr[7:2];
  assign w_wr               = we & addr[7];
  assign w_unused_addr_bits = ^{addr[31:8], addr[1:0]};
  assign w_raw[0]           = in_port0;
  assign w_raw[1]           = in_port1;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchronizer, candidate/stability counter, debounced
  // value. The change pulse is combinational so STATUS sets on the same edge
  // as the debounced register.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [IN_WIDTH-1:0] r_cand;
    logic [IN_WIDTH-1:0] r_deb;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                w_differs;
    logic                w_upd;

    // Decide whether this edge accepts a new debounced value. With a window
    // of one sample, loading the candidate is itself the accepting sample.
    always_comb begin
      w_differs = (r_sync2 != r_cand);
      if (w_differs) begin
        w_upd = c_db_one && (r_sync2 != r_deb);
      end else begin
        w_upd = (r_cnt == c_db_last) && (r_cand != r_deb);
      end
    end

    // Synchronize, track stability of the candidate and commit accepted values.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_sync1 <= '0;
        r_sync2 <= '0;
        r_cand  <= '0;
        r_cnt   <= '0;
        r_deb   <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        if (w_differs) begin
          r_cand <= r_sync2;
          r_cnt  <= c_cnt_w'(1);
        end else if (r_cnt < c_db_max) begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
        if (w_upd) begin
          r_deb <= w_differs ? r_sync2 : r_cand;
        end
      end
    end

    assign w_in_chg[gi] = w_upd;
    assign w_in_deb[gi] = r_deb;
  end

  // Timer hit uses the COMPARE value held before this edge, so a COMPARE
  // store only affects the comparison of the following cycle.
  assign w_timer_hit  = r_timer_en && (r_count == r_compare);
  assign w_status_set = {w_timer_hit, w_in_chg};
  assign w_status_clr = (w_wr && (w_off == c_off_status)) ? wdata[2:0] : 3'b000;

  // Timer counter: CPU store wins over both increment and wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr && (w_off == c_off_count)) begin
      r_count <= wdata;
    end else if (r_timer_en) begin
      r_count <= w_timer_hit ? 32'd0 : (r_count + 32'd1);
    end
  end

  // Sticky status: a set in the same cycle as its W1C clear leaves the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | w_status_set;
    end
  end

  // CPU-writable control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_mask <= '0;
      r_out0     <= '0;
      r_out1     <= '0;
      r_out2     <= '0;
      r_out3     <= '0;
      r_compare  <= 32'hFFFF_FFFF;
      r_timer_en <= 1'b0;
    end else if (w_wr) begin
      case (w_off)
        c_off_mask:    r_irq_mask <= wdata[2:0];
        c_off_out0:    r_out0     <= wdata;
        c_off_out1:    r_out1     <= wdata;
        c_off_out2:    r_out2     <= wdata;
        c_off_out3:    r_out3     <= wdata;
        c_off_compare: r_compare  <= wdata;
        c_off_ctrl:    r_timer_en <= wdata[0];
        default:       ;
      endcase
    end
  end

  // Zero-wait-state load mux; anything outside the region or unmapped reads 0.
  always_comb begin
    rdata = 32'd0;
    if (addr[7]) begin
      case (w_off)
        c_off_in0:     rdata = 32'(w_in_deb[0]);
        c_off_in1:     rdata = 32'(w_in_deb[1]);
        c_off_status:  rdata = {29'd0, r_status};
        c_off_mask:    rdata = {29'd0, r_irq_mask};
        c_off_out0:    rdata = r_out0;
        c_off_out1:    rdata = r_out1;
        c_off_out2:    rdata = r_out2;
        c_off_out3:    rdata = r_out3;
        c_off_count:   rdata = r_count;
        c_off_compare: rdata = r_compare;
        c_off_ctrl:    rdata = {31'd0, r_timer_en};
        default:       rdata = 32'd0;
      endcase
    end
  end

  assign out_port0 = r_out0;
  assign out_port1 = r_out1;
  assign out_port2 = r_out2;
  assign out_port3 = r_out3;
  assign irq       = |(r_status & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_mmio_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_port_responder
//  Brief    : Self-checking bench for mmio_port_responder: directed scenarios
//             followed by randomized bus and switch traffic, checked against a
//             register-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_port_responder;

  localparam int W  = 6;
  localparam int DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   addr;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [W-1:0]  in_port0;
  logic [W-1:0]  in_port1;
  logic [31:0]   out_port0;
  logic [31:0]   out_port1;
  logic [31:0]   out_port2;
  logic [31:0]   out_port3;
  logic          irq;

  mmio_port_responder #(.IN_WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .out_port3 (out_port3),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  // Reference model state.
  logic [W-1:0]  m_in   [2];
  logic [W-1:0]  m_s1   [2];
  logic [W-1:0]  m_s2   [2];
  logic [W-1:0]  m_win  [2][DB];
  int            m_nwin [2];
  logic [2:0]    m_status;
  logic [2:0]    m_mask;
  logic [31:0]   m_out  [4];
  logic [31:0]   m_count;
  logic [31:0]   m_compare;
  logic          m_en;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    if (!a[7]) return 32'd0;
    case (b)
      8'h80: return 32'(m_in[0]);
      8'h84: return 32'(m_in[1]);
      8'h88: return {29'd0, m_status};
      8'h8C: return {29'd0, m_mask};
      8'hC0: return m_out[0];
      8'hC4: return m_out[1];
      8'hC8: return m_out[2];
      8'hCC: return m_out[3];
      8'hD0: return m_count;
      8'hD4: return m_compare;
      8'hD8: return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [2:0]   set_b;
    logic [2:0]   clr_b;
    logic         wr;
    logic         hit;
    logic         same;
    logic [7:0]   b;
    logic [W-1:0] raw [2];
    raw[0] = in_port0;
    raw[1] = in_port1;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_in[p] = '0; m_s1[p] = '0; m_s2[p] = '0; m_nwin[p] = 0;
      end
      m_status = '0; m_mask = '0; m_count = '0; m_compare = 32'hFFFF_FFFF; m_en = 1'b0;
      for (int k = 0; k < 4; k++) m_out[k] = '0;
      return;
    end
    set_b = '0;
    // Accept a value once the last DB synchronized samples all agree on it.
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DB - 1; k++) m_win[p][k] = m_win[p][k+1];
      m_win[p][DB-1] = m_s2[p];
      if (m_nwin[p] < DB) m_nwin[p]++;
      same = (m_nwin[p] == DB);
      for (int k = 0; k < DB; k++) if (m_win[p][k] != m_win[p][DB-1]) same = 1'b0;
      if (same && (m_win[p][DB-1] != m_in[p])) begin
        m_in[p]  = m_win[p][DB-1];
        set_b[p] = 1'b1;
      end
      m_s2[p] = m_s1[p];
      m_s1[p] = raw[p];
    end
    wr  = we && addr[7];
    b   = addr[7:0] & 8'hFC;
    hit = m_en && (m_count == m_compare);
    if (hit) set_b[2] = 1'b1;
    if (wr && b == 8'hD0)  m_count = wdata;
    else if (m_en)         m_count = hit ? 32'd0 : m_count + 32'd1;
    clr_b    = (wr && b == 8'h88) ? wdata[2:0] : 3'b000;
    m_status = (m_status & ~clr_b) | set_b;
    if (wr) begin
      case (b)
        8'h8C: m_mask    = wdata[2:0];
        8'hC0: m_out[0]  = wdata;
        8'hC4: m_out[1]  = wdata;
        8'hC8: m_out[2]  = wdata;
        8'hCC: m_out[3]  = wdata;
        8'hD4: m_compare = wdata;
        8'hD8: m_en      = wdata[0];
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  // One bus cycle: apply, check every output against the model, then clock.
  task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d,
                    input string tag, output logic [31:0] rd);
    addr = a; we = w; wdata = d;
    #1;
    rd = rdata;
    chk(tag, rdata, m_read(a));
    chk("out_port0", out_port0, m_out[0]);
    chk("out_port1", out_port1, m_out[1]);
    chk("out_port2", out_port2, m_out[2]);
    chk("out_port3", out_port3, m_out[3]);
    chk("irq", {31'd0, irq}, {31'd0, |(m_status & m_mask)});
    tick();
    we = 1'b0;
  endtask

  function automatic logic [31:0] ra(input logic [7:0] off);
    logic [31:0] a;
    a      = $urandom;
    a[7:0] = off;
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [7:0]  offs [13];
    logic [31:0] exp_cnt [5];
    logic [7:0]  o;
    logic [31:0] d;
    int          hold0;
    int          hold1;

    offs = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'hC0, 8'hC4, 8'hC8, 8'hCC,
             8'hD0, 8'hD4, 8'hD8, 8'h9C, 8'hE4};
    exp_cnt = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; in_port0 = '0; in_port1 = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values of every mapped offset, one unmapped offset, and sel=0.
    for (int i = 0; i < 11; i++) begin
      op(ra(offs[i]) | 32'(i % 4), 1'b0, 32'd0, "reset_read", rd);
      chk("reset_literal", rd, (offs[i] == 8'hD4) ? 32'hFFFF_FFFF : 32'd0);
    end
    op(ra(8'h9C), 1'b0, 32'd0, "unmapped_read", rd);
    chk("unmapped_literal", rd, 32'd0);
    op(32'h0000_0040, 1'b0, 32'd0, "sel0_read", rd);
    chk("sel0_literal", rd, 32'd0);

    // Output-port store and readback; store to a read-only register.
    op(ra(8'hC4), 1'b1, 32'h0000_00A5, "store_out1", rd);
    chk("out1_after_store", out_port1, 32'h0000_00A5);
    op(ra(8'hC4), 1'b0, 32'd0, "load_out1", rd);
    chk("load_out1_literal", rd, 32'h0000_00A5);
    op(ra(8'h80), 1'b1, $urandom, "store_in0_ro", rd);
    op(ra(8'h80), 1'b0, 32'd0, "in0_after_ro_store", rd);
    chk("in0_ro_literal", rd, 32'd0);
    op(32'h0000_0044, 1'b1, 32'h1234_5678, "store_sel0", rd);
    chk("sel0_store_ignored", out_port1, 32'h0000_00A5);

    // Debounce latency: IN0 updates exactly 2 + DB edges after the raw change.
    in_port0 = 6'h2A;
    for (int k = 0; k <= 2 + DB; k++) begin
      op(ra(8'h80), 1'b0, 32'd0, "in0_latency", rd);
      chk("in0_latency_literal", rd, (k < 2 + DB) ? 32'd0 : 32'h2A);
    end
    op(ra(8'h88), 1'b0, 32'd0, "status_in0", rd);
    chk("status_in0_literal", rd, 32'h1);
    op(ra(8'h88), 1'b1, 32'h1, "w1c_in0", rd);
    op(ra(8'h88), 1'b0, 32'd0, "status_cleared", rd);
    chk("status_cleared_literal", rd, 32'h0);

    // A glitch shorter than the debounce window is rejected.
    in_port1 = W'($urandom_range(1, (1 << W) - 1));
    for (int k = 0; k < 3; k++) op(ra(8'h84), 1'b0, 32'd0, "glitch_in1", rd);
    in_port1 = '0;
    for (int k = 0; k < 10; k++) op(ra(8'h84), 1'b0, 32'd0, "glitch_in1_after", rd);
    chk("glitch_in1_literal", rd, 32'd0);
    op(ra(8'h88), 1'b0, 32'd0, "glitch_status", rd);
    chk("glitch_status_literal", rd, 32'd0);

    // Timer: COUNT runs 1,2,3,0 with COMPARE=3 and sets STATUS.2 on the wrap.
    op(ra(8'h8C), 1'b1, 32'h4, "set_mask", rd);
    op(ra(8'hD4), 1'b1, 32'h3, "set_compare", rd);
    op(ra(8'hD8), 1'b1, 32'h1, "set_ctrl", rd);
    for (int k = 0; k < 5; k++) begin
      op(ra(8'hD0), 1'b0, 32'd0, "count_seq", rd);
      chk("count_seq_literal", rd, exp_cnt[k]);
    end
    chk("irq_on_wrap", {31'd0, irq}, 32'd1);
    op(ra(8'h88), 1'b1, 32'h4, "w1c_timer", rd);
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    op(ra(8'h88), 1'b0, 32'd0, "status_after_w1c", rd);
    chk("status_after_w1c_literal", rd, 32'd0);

    // COUNT==COMPARE now: W1C in the hit cycle leaves STATUS.2 set.
    op(ra(8'h88), 1'b1, 32'h4, "w1c_on_hit", rd);
    op(ra(8'h88), 1'b0, 32'd0, "status_set_wins", rd);
    chk("status_set_wins_literal", rd, 32'h4);
    op(ra(8'h88), 1'b1, 32'h4, "w1c_again", rd);
    op(ra(8'hD0), 1'b0, 32'd0, "count_before_wrap", rd);
    chk("count_before_wrap_literal", rd, 32'd2);
    op(ra(8'hD0), 1'b1, 32'h10, "count_store_on_wrap", rd);
    op(ra(8'hD0), 1'b0, 32'd0, "count_store_wins", rd);
    chk("count_store_wins_literal", rd, 32'h10);

    // Mid-operation reset discards the coinciding store.
    op(ra(8'hCC), 1'b1, 32'hFFFF_FFFF, "store_out3", rd);
    chk("out3_all_ones", out_port3, 32'hFFFF_FFFF);
    reset = 1'b1;
    op(ra(8'hC0), 1'b1, 32'h1234_5678, "store_during_reset", rd);
    reset = 1'b0;
    chk("reset_out0", out_port0, 32'd0);
    chk("reset_out1", out_port1, 32'd0);
    chk("reset_out3", out_port3, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    op(ra(8'hD0), 1'b0, 32'd0, "count_after_reset", rd);
    chk("count_after_reset_literal", rd, 32'd0);
    op(ra(8'hD4), 1'b0, 32'd0, "compare_after_reset", rd);
    chk("compare_after_reset_literal", rd, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    hold0 = 0;
    hold1 = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold0 == 0) begin
        in_port0 = W'($urandom);
        hold0    = $urandom_range(1, 9);
      end else hold0--;
      if (hold1 == 0) begin
        in_port1 = W'($urandom);
        hold1    = $urandom_range(1, 9);
      end else hold1--;
      o = offs[$urandom_range(0, 12)];
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
      if (o == 8'hD8) d = 32'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) op({ra(o)} & 32'hFFFF_FF7F, 1'b1, d, "rand_sel0", rd);
      else op(ra(o), 1'($urandom_range(0, 1)), d, "rand_read", rd);
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
